// File: rtl/shared_memory_arbiter.sv
// shared_memory_arbiter
//   Round-robin arbiter that lets NUM_MASTERS Avalon-MM pipelined masters share
//   one single-port memory. The memory returns read data one cycle after the address.
//   At most one command is issued per cycle. Read data is returned with a one-hot
//   readdatavalid. A master can hold the grant for up to LOCK_MAX commands with
//   m_lock, which supports atomic read-modify-write sequences.
// Ports:
//   clk, reset         : clock, synchronous active-high reset
//   m_address/byteenable/writedata : packed per-master command fields (master i at slice i)
//   m_read/m_write/m_lock : per-master request and lock inputs
//   m_waitrequest      : per-master stall (low only for the granted master)
//   m_readdata         : read data broadcast to all masters
//   m_readdatavalid    : one-hot marker of the master that owns m_readdata
//   mem_*              : single memory port (mem_readdata valid the cycle after a read)
module shared_memory_arbiter #(
    parameter int NUM_MASTERS = 4,
    parameter int ADDR_WIDTH  = 16,
    parameter int DATA_WIDTH  = 32,
    parameter int LOCK_MAX    = 16
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0]   m_address,
    input  logic [NUM_MASTERS*DATA_WIDTH/8-1:0] m_byteenable,
    input  logic [NUM_MASTERS-1:0]              m_read,
    input  logic [NUM_MASTERS-1:0]              m_write,
    input  logic [NUM_MASTERS*DATA_WIDTH-1:0]   m_writedata,
    input  logic [NUM_MASTERS-1:0]              m_lock,
    output logic [NUM_MASTERS-1:0]              m_waitrequest,
    output logic [DATA_WIDTH-1:0]               m_readdata,
    output logic [NUM_MASTERS-1:0]              m_readdatavalid,
    output logic [ADDR_WIDTH-1:0]               mem_address,
    output logic [DATA_WIDTH/8-1:0]             mem_byteenable,
    output logic                                mem_chipselect,
    output logic                                mem_write,
    output logic [DATA_WIDTH-1:0]               mem_writedata,
    input  logic [DATA_WIDTH-1:0]               mem_readdata
);

    localparam int IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam int BE_W  = DATA_WIDTH / 8;

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t                   state_q, state_d;
    logic [IDX_W-1:0]         ptr_q, ptr_d;
    logic [IDX_W-1:0]         owner_q, owner_d;
    logic [7:0]               lock_cnt_q, lock_cnt_d;
    logic [NUM_MASTERS-1:0]   lock_block_q, lock_block_d;
    logic                     rd_valid_q, rd_valid_d;
    logic [IDX_W-1:0]         rd_owner_q, rd_owner_d;
    logic [ADDR_WIDTH-1:0]    addr_hold_q, addr_hold_d;
    logic [BE_W-1:0]          be_hold_q, be_hold_d;
    logic [DATA_WIDTH-1:0]    wdata_hold_q, wdata_hold_d;

    logic [NUM_MASTERS-1:0]   req;
    logic                     grant_any;
    logic [IDX_W-1:0]         grant_idx;
    logic                     grant_is_write;
    logic [IDX_W:0]           cand;

    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] g);
        if (g == IDX_W'(NUM_MASTERS - 1)) return '0;
        return g + 1'b1;
    endfunction

    // Grant selection. A locked owner that is requesting wins outright; otherwise
    // the first requester at or after ptr wins. Reset blocks every grant.
    always_comb begin
        req       = m_read | m_write;
        grant_any = 1'b0;
        grant_idx = '0;
        cand      = '0;
        if (!reset) begin
            if (state_q == LOCKED && req[owner_q]) begin
                grant_any = 1'b1;
                grant_idx = owner_q;
            end else begin
                for (int k = 0; k < NUM_MASTERS; k++) begin
                    cand = {1'b0, ptr_q} + (IDX_W+1)'(k);
                    if (cand >= (IDX_W+1)'(NUM_MASTERS)) cand = cand - (IDX_W+1)'(NUM_MASTERS);
                    if (!grant_any && req[cand[IDX_W-1:0]]) begin
                        grant_any = 1'b1;
                        grant_idx = cand[IDX_W-1:0];
                    end
                end
            end
        end
        // A simultaneous read and write is issued as a write.
        grant_is_write = grant_any && m_write[grant_idx];
    end

    // Command mux. When nothing is issued, the memory sees the last command fields.
    always_comb begin
        addr_hold_d  = addr_hold_q;
        be_hold_d    = be_hold_q;
        wdata_hold_d = wdata_hold_q;
        if (grant_any) begin
            addr_hold_d  = m_address[grant_idx*ADDR_WIDTH +: ADDR_WIDTH];
            be_hold_d    = m_byteenable[grant_idx*BE_W +: BE_W];
            wdata_hold_d = m_writedata[grant_idx*DATA_WIDTH +: DATA_WIDTH];
        end
        mem_address     = addr_hold_d;
        mem_byteenable  = be_hold_d;
        mem_writedata   = wdata_hold_d;
        mem_chipselect  = grant_any;
        mem_write       = grant_is_write;
        m_waitrequest   = ~(grant_any ? (NUM_MASTERS'(1) << grant_idx) : '0);
        rd_valid_d      = grant_any && !grant_is_write;
        rd_owner_d      = grant_idx;
        // Gating with reset drops a return that lands in a reset cycle.
        m_readdata      = mem_readdata;
        m_readdatavalid = (rd_valid_q && !reset) ? (NUM_MASTERS'(1) << rd_owner_q) : '0;
    end

    // Pointer and lock FSM
    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        owner_d      = owner_q;
        lock_cnt_d   = lock_cnt_q;
        // A block clears as soon as its master drops m_lock.
        lock_block_d = lock_block_q & m_lock;
        if (state_q == IDLE) begin
            if (grant_any) begin
                ptr_d = next_idx(grant_idx);
                if (m_lock[grant_idx] && !lock_block_q[grant_idx]) begin
                    owner_d    = grant_idx;
                    lock_cnt_d = 8'd1;
                    // A limit of one is used up by the locking grant itself.
                    if (LOCK_MAX == 1) lock_block_d[grant_idx] = 1'b1;
                    else               state_d = LOCKED;
                end
            end
        end else begin
            if (!m_lock[owner_q]) begin
                state_d = IDLE;
                ptr_d   = next_idx(owner_q);
            end else if (grant_any && grant_idx == owner_q) begin
                lock_cnt_d = lock_cnt_q + 8'd1;
                if (lock_cnt_d == 8'(LOCK_MAX)) begin
                    state_d               = IDLE;
                    lock_block_d[owner_q] = 1'b1;
                    ptr_d                 = next_idx(owner_q);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            ptr_q        <= '0;
            owner_q      <= '0;
            lock_cnt_q   <= '0;
            lock_block_q <= '0;
            rd_valid_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            owner_q      <= owner_d;
            lock_cnt_q   <= lock_cnt_d;
            lock_block_q <= lock_block_d;
            rd_valid_q   <= rd_valid_d;
        end
    end

    // Datapath registers are not reset.
    always_ff @(posedge clk) begin
        rd_owner_q   <= rd_owner_d;
        addr_hold_q  <= addr_hold_d;
        be_hold_q    <= be_hold_d;
        wdata_hold_q <= wdata_hold_d;
    end

endmodule

// File: tb/tb_shared_memory_arbiter.sv
module tb_shared_memory_arbiter;

    logic         clk = 1'b0;
    logic         reset;
    logic [63:0]  m_address;
    logic [15:0]  m_byteenable;
    logic [3:0]   m_read, m_write, m_lock;
    logic [127:0] m_writedata;
    logic [3:0]   m_waitrequest, m_readdatavalid;
    logic [31:0]  m_readdata;
    logic [15:0]  mem_address;
    logic [3:0]   mem_byteenable;
    logic         mem_chipselect, mem_write;
    logic [31:0]  mem_writedata, mem_readdata;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    shared_memory_arbiter dut (
        .clk(clk), .reset(reset),
        .m_address(m_address), .m_byteenable(m_byteenable),
        .m_read(m_read), .m_write(m_write), .m_writedata(m_writedata),
        .m_lock(m_lock), .m_waitrequest(m_waitrequest),
        .m_readdata(m_readdata), .m_readdatavalid(m_readdatavalid),
        .mem_address(mem_address), .mem_byteenable(mem_byteenable),
        .mem_chipselect(mem_chipselect), .mem_write(mem_write),
        .mem_writedata(mem_writedata), .mem_readdata(mem_readdata)
    );

    // Behavioural single-port memory with one-cycle read latency
    logic [31:0] mem [0:65535];
    always @(posedge clk) begin
        if (mem_chipselect) begin
            if (mem_write) begin
                for (int b = 0; b < 4; b++)
                    if (mem_byteenable[b]) mem[mem_address][b*8 +: 8] <= mem_writedata[b*8 +: 8];
            end else begin
                mem_readdata <= mem[mem_address];
            end
        end
    end

    typedef struct {
        logic [3:0]  rd;
        logic [3:0]  wr;
        logic [3:0]  exp_wait;
        logic [3:0]  exp_rdv;
        logic        exp_cs;
        logic        exp_we;
        logic [31:0] exp_data;
    } vec_t;

    vec_t vecs [19];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic [3:0] rd, input logic [3:0] wr, input logic [3:0] lk);
        m_read  = rd;
        m_write = wr;
        m_lock  = lk;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int a = 0; a < 65536; a++) mem[a] = 32'h0;
        mem[16'h0010] = 32'hDEADBEEF;
        mem[16'h0020] = 32'hA5A50001;
        mem[16'h0030] = 32'hCAFEF00D;
        mem_readdata = 32'h0;

        m_address    = {16'h0030, 16'h0100, 16'h0020, 16'h0010};
        m_byteenable = {4'hF, 4'b0101, 4'hF, 4'hF};
        m_writedata  = {32'h33333333, 32'h11223344, 32'h11111111, 32'h00000000};

        // rd, wr, exp_wait, exp_rdv, exp_cs, exp_we, exp_data
        vecs[0]  = '{4'b0001, 4'b0000, 4'b1110, 4'b0000, 1'b1, 1'b0, 32'h0};
        vecs[1]  = '{4'b0000, 4'b0100, 4'b1011, 4'b0001, 1'b1, 1'b1, 32'hDEADBEEF};
        vecs[2]  = '{4'b0100, 4'b0000, 4'b1011, 4'b0000, 1'b1, 1'b0, 32'h0};
        vecs[3]  = '{4'b0000, 4'b0000, 4'b1111, 4'b0100, 1'b0, 1'b0, 32'h00220044};
        vecs[4]  = '{4'b0001, 4'b0000, 4'b1110, 4'b0000, 1'b1, 1'b0, 32'h0};
        vecs[5]  = '{4'b1000, 4'b0000, 4'b0111, 4'b0001, 1'b1, 1'b0, 32'hDEADBEEF};
        vecs[6]  = '{4'b0001, 4'b0000, 4'b1110, 4'b1000, 1'b1, 1'b0, 32'hCAFEF00D};
        vecs[7]  = '{4'b1000, 4'b0000, 4'b0111, 4'b0001, 1'b1, 1'b0, 32'hDEADBEEF};
        vecs[8]  = '{4'b0000, 4'b0000, 4'b1111, 4'b1000, 1'b0, 1'b0, 32'hCAFEF00D};
        vecs[9]  = '{4'b1001, 4'b0000, 4'b1110, 4'b0000, 1'b1, 1'b0, 32'h0};
        vecs[10] = '{4'b1001, 4'b0000, 4'b0111, 4'b0001, 1'b1, 1'b0, 32'hDEADBEEF};
        vecs[11] = '{4'b0000, 4'b0000, 4'b1111, 4'b1000, 1'b0, 1'b0, 32'hCAFEF00D};
        vecs[12] = '{4'b0000, 4'b1111, 4'b1110, 4'b0000, 1'b1, 1'b1, 32'h0};
        vecs[13] = '{4'b0000, 4'b1111, 4'b1101, 4'b0000, 1'b1, 1'b1, 32'h0};
        vecs[14] = '{4'b0000, 4'b1111, 4'b1011, 4'b0000, 1'b1, 1'b1, 32'h0};
        vecs[15] = '{4'b0000, 4'b1111, 4'b0111, 4'b0000, 1'b1, 1'b1, 32'h0};
        vecs[16] = '{4'b0000, 4'b1111, 4'b1110, 4'b0000, 1'b1, 1'b1, 32'h0};
        vecs[17] = '{4'b0010, 4'b0010, 4'b1101, 4'b0000, 1'b1, 1'b1, 32'h0};
        vecs[18] = '{4'b0000, 4'b0000, 4'b1111, 4'b0000, 1'b0, 1'b0, 32'h0};

        // Reset state, with every master requesting
        reset = 1'b1;
        drive(4'b1111, 4'b0000, 4'b0000);
        next_cycle();
        @(negedge clk);
        check("reset_wait", 32'(m_waitrequest), 32'hF);
        check("reset_cs", 32'(mem_chipselect), 32'h0);
        check("reset_rdv", 32'(m_readdatavalid), 32'h0);
        next_cycle();
        reset = 1'b0;
        drive(4'b0000, 4'b0000, 4'b0000);

        // Table: single read, masked write/readback, alternating reads, write rotation
        for (int i = 0; i < 19; i++) begin
            drive(vecs[i].rd, vecs[i].wr, 4'b0000);
            @(negedge clk);
            check($sformatf("v%0d_wait", i), 32'(m_waitrequest), 32'(vecs[i].exp_wait));
            check($sformatf("v%0d_cs", i), 32'(mem_chipselect), 32'(vecs[i].exp_cs));
            check($sformatf("v%0d_we", i), 32'(mem_write), 32'(vecs[i].exp_we));
            check($sformatf("v%0d_rdv", i), 32'(m_readdatavalid), 32'(vecs[i].exp_rdv));
            if (vecs[i].exp_rdv != 4'b0000)
                check($sformatf("v%0d_data", i), m_readdata, vecs[i].exp_data);
            next_cycle();
        end
        // Idle memory port keeps the last command address (master 1 at 0x0020)
        check("idle_addr_hold", 32'(mem_address), 32'h0020);

        // Lock: master 1 gets exactly LOCK_MAX grants, then is blocked until it drops m_lock
        reset = 1'b1;
        drive(4'b0000, 4'b0000, 4'b0000);
        next_cycle();
        reset = 1'b0;
        drive(4'b0010, 4'b0000, 4'b0010);
        @(negedge clk);
        check("lock_g0", 32'(m_waitrequest), 32'b1101);
        next_cycle();
        for (int c = 1; c < 16; c++) begin
            drive(4'b1111, 4'b0000, 4'b0010);
            @(negedge clk);
            check($sformatf("lock_g%0d", c), 32'(m_waitrequest), 32'b1101);
            next_cycle();
        end
        begin
            logic [3:0] after_lock [5];
            after_lock = '{4'b1011, 4'b0111, 4'b1110, 4'b1101, 4'b1011};
            for (int c = 0; c < 5; c++) begin
                drive(4'b1111, 4'b0000, 4'b0010);
                @(negedge clk);
                check($sformatf("lock_after%0d", c), 32'(m_waitrequest), 32'(after_lock[c]));
                next_cycle();
            end
        end
        drive(4'b0000, 4'b0000, 4'b0000);
        next_cycle();
        drive(4'b0010, 4'b0000, 4'b0010);
        @(negedge clk);
        check("relock_g0", 32'(m_waitrequest), 32'b1101);
        next_cycle();
        drive(4'b1111, 4'b0000, 4'b0010);
        @(negedge clk);
        check("relock_g1", 32'(m_waitrequest), 32'b1101);
        next_cycle();
        drive(4'b0000, 4'b0000, 4'b0000);
        next_cycle();
        drive(4'b1111, 4'b0000, 4'b0000);
        @(negedge clk);
        check("unlock_ptr", 32'(m_waitrequest), 32'b1011);
        next_cycle();

        // Reset in the return cycle of a master 3 read suppresses readdatavalid
        drive(4'b1000, 4'b0000, 4'b0000);
        @(negedge clk);
        check("rst_rd_issue", 32'(m_waitrequest), 32'b0111);
        next_cycle();
        reset = 1'b1;
        drive(4'b1111, 4'b0000, 4'b0000);
        @(negedge clk);
        check("rst_rdv_supp", 32'(m_readdatavalid), 32'h0);
        check("rst_wait_all", 32'(m_waitrequest), 32'hF);
        check("rst_cs", 32'(mem_chipselect), 32'h0);
        check("rst_we", 32'(mem_write), 32'h0);
        next_cycle();
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_grant", 32'(m_waitrequest), 32'b1110);
        check("post_rst_rdv", 32'(m_readdatavalid), 32'h0);
        next_cycle();

        // Pointer returns to 0 after reset even when it was elsewhere
        drive(4'b0010, 4'b0000, 4'b0000);
        next_cycle();
        reset = 1'b1;
        drive(4'b0000, 4'b0000, 4'b0000);
        next_cycle();
        reset = 1'b0;
        drive(4'b1111, 4'b0000, 4'b0000);
        @(negedge clk);
        check("ptr_reset", 32'(m_waitrequest), 32'b1110);
        next_cycle();
        drive(4'b0000, 4'b0000, 4'b0000);
        next_cycle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
